// File: rtl/pipe_pkg.sv
// Shared definitions for the 16-bit pipeline: opcodes, the decode stage
// state encoding, default widths and the immediate sign-extension helper.
package pipe_pkg;

    localparam int ARQ_DEF       = 16;
    localparam int REG_COUNT_DEF = 16;
    localparam int REG_ADDR_DEF  = 4;

    localparam logic [3:0] OP_ADD    = 4'h0;
    localparam logic [3:0] OP_SUB    = 4'h1;
    localparam logic [3:0] OP_AND    = 4'h2;
    localparam logic [3:0] OP_OR     = 4'h3;
    localparam logic [3:0] OP_ADDI   = 4'h4;
    localparam logic [3:0] OP_LOAD   = 4'h8;
    localparam logic [3:0] OP_STORE  = 4'h9;
    localparam logic [3:0] OP_BRANCH = 4'hA;
    localparam logic [3:0] OP_NOP    = 4'hF;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        HOLD   = 2'd1,
        BUBBLE = 2'd2
    } stage_state_e;

    // Sign-extend the 4-bit immediate field to the 16-bit datapath.
    function automatic logic [15:0] sext_imm4(input logic [3:0] imm);
        sext_imm4 = {{12{imm[3]}}, imm};
    endfunction

endpackage

// File: rtl/reg_file.sv
// Architectural register file: three asynchronous read ports, one write
// port from writeback, R0 hard-wired to zero and same-cycle write-through.
module reg_file
    import pipe_pkg::*;
#(
    parameter int ARQ       = ARQ_DEF,
    parameter int REG_COUNT = REG_COUNT_DEF,
    parameter int REG_ADDR  = REG_ADDR_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wb_enable,
    input  logic [REG_ADDR-1:0] wb_addr,
    input  logic [ARQ-1:0]      wb_result,
    input  logic [REG_ADDR-1:0] rs1_addr,
    input  logic [REG_ADDR-1:0] rs2_addr,
    input  logic [REG_ADDR-1:0] rd_addr,
    output logic [ARQ-1:0]      rs1_data,
    output logic [ARQ-1:0]      rs2_data,
    output logic [ARQ-1:0]      rd_data
);

    logic [ARQ-1:0]      regs_r     [REG_COUNT];
    logic [REG_ADDR-1:0] rd_addr_s  [3];
    logic [ARQ-1:0]      rd_value_s [3];

    assign rd_addr_s[0] = rs1_addr;
    assign rd_addr_s[1] = rs2_addr;
    assign rd_addr_s[2] = rd_addr;
    assign rs1_data     = rd_value_s[0];
    assign rs2_data     = rd_value_s[1];
    assign rd_data      = rd_value_s[2];

    // Register storage: cleared on reset, R0 is never written.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                regs_r[i] <= {ARQ{1'b0}};
            end
        end else if (wb_enable && (wb_addr != {REG_ADDR{1'b0}})) begin
            regs_r[wb_addr] <= wb_result;
        end
    end

    // Read ports: R0 reads zero, a pending writeback to the same register
    // is forwarded so the decoder sees the value being written this cycle.
    always_comb begin
        for (int p = 0; p < 3; p++) begin
            rd_value_s[p] = {ARQ{1'b0}};
            if (rd_addr_s[p] == {REG_ADDR{1'b0}}) begin
                rd_value_s[p] = {ARQ{1'b0}};
            end else if (wb_enable && (wb_addr == rd_addr_s[p])) begin
                rd_value_s[p] = wb_result;
            end else begin
                rd_value_s[p] = regs_r[rd_addr_s[p]];
            end
        end
    end

endmodule

// File: rtl/decode_rf_stage.sv
// Decode / register-read stage: decodes the fetched instruction, reads its
// operands and issues a registered bundle to the ALU stage, honouring
// flush, downstream stall and a one-bubble load-use interlock.
module decode_rf_stage
    import pipe_pkg::*;
#(
    parameter int ARQ       = ARQ_DEF,
    parameter int REG_COUNT = REG_COUNT_DEF,
    parameter int REG_ADDR  = REG_ADDR_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ARQ-1:0]      instr_in,
    input  logic                instr_valid,
    output logic                instr_ready,
    input  logic                stall_in,
    input  logic                flush,
    input  logic                wb_enable,
    input  logic [REG_ADDR-1:0] wb_addr,
    input  logic [ARQ-1:0]      wb_result,
    output logic [3:0]          opcode_out,
    output logic [REG_ADDR-1:0] rd_out,
    output logic [ARQ-1:0]      opa_out,
    output logic [ARQ-1:0]      opb_out,
    output logic [ARQ-1:0]      store_data_out,
    output logic                wr_reg_en_out,
    output logic                valid_out,
    output logic [15:0]         issue_count
);

    // Instruction fields
    logic [3:0]          opcode_s;
    logic [REG_ADDR-1:0] rd_s;
    logic [REG_ADDR-1:0] rs1_s;
    logic [REG_ADDR-1:0] rs2_s;
    logic [3:0]          imm4_s;

    assign opcode_s = instr_in[15:12];
    assign rd_s     = instr_in[11:8];
    assign rs1_s    = instr_in[7:4];
    assign rs2_s    = instr_in[3:0];
    assign imm4_s   = instr_in[3:0];

    logic [ARQ-1:0] rs1_data_s;
    logic [ARQ-1:0] rs2_data_s;
    logic [ARQ-1:0] rd_data_s;

    reg_file #(
        .ARQ       (ARQ),
        .REG_COUNT (REG_COUNT),
        .REG_ADDR  (REG_ADDR)
    ) u_reg_file (
        .clk       (clk),
        .rst       (rst),
        .wb_enable (wb_enable),
        .wb_addr   (wb_addr),
        .wb_result (wb_result),
        .rs1_addr  (rs1_s),
        .rs2_addr  (rs2_s),
        .rd_addr   (rd_s),
        .rs1_data  (rs1_data_s),
        .rs2_data  (rs2_data_s),
        .rd_data   (rd_data_s)
    );

    // Registered state
    stage_state_e        state_r;
    logic [3:0]          opcode_r;
    logic [REG_ADDR-1:0] rd_r;
    logic [ARQ-1:0]      opa_r;
    logic [ARQ-1:0]      opb_r;
    logic [ARQ-1:0]      store_data_r;
    logic                wr_reg_en_r;
    logic                valid_r;
    logic [15:0]         issue_count_r;

    assign opcode_out     = opcode_r;
    assign rd_out         = rd_r;
    assign opa_out        = opa_r;
    assign opb_out        = opb_r;
    assign store_data_out = store_data_r;
    assign wr_reg_en_out  = wr_reg_en_r;
    assign valid_out      = valid_r;
    assign issue_count    = issue_count_r;

    // Decoded bundle and interlock
    logic           is_store_s;
    logic           use_imm_s;
    logic           dec_wr_en_s;
    logic [ARQ-1:0] dec_opb_s;
    logic [ARQ-1:0] dec_store_s;
    logic           hazard_s;

    // Operand select and write-enable decode for the incoming instruction.
    always_comb begin
        is_store_s  = 1'b0;
        use_imm_s   = 1'b0;
        dec_wr_en_s = 1'b1;
        case (opcode_s)
            OP_ADDI:   use_imm_s = 1'b1;
            OP_LOAD:   use_imm_s = 1'b1;
            OP_STORE: begin
                use_imm_s   = 1'b1;
                is_store_s  = 1'b1;
                dec_wr_en_s = 1'b0;
            end
            OP_BRANCH: dec_wr_en_s = 1'b0;
            OP_NOP:    dec_wr_en_s = 1'b0;
            default: begin
                use_imm_s   = 1'b0;
                dec_wr_en_s = 1'b1;
            end
        endcase
        if (use_imm_s) begin
            dec_opb_s = sext_imm4(imm4_s);
        end else begin
            dec_opb_s = rs2_data_s;
        end
        if (is_store_s) begin
            dec_store_s = rd_data_s;
        end else begin
            dec_store_s = {ARQ{1'b0}};
        end
    end

    // Load-use check: the issued LOAD's result is not yet in the register
    // file, so a dependent instruction must wait one cycle.
    always_comb begin
        hazard_s = valid_r && (opcode_r == OP_LOAD) && (rd_r != {REG_ADDR{1'b0}})
                   && instr_valid
                   && ((rd_r == rs1_s) || (rd_r == rs2_s) || (is_store_s && (rd_r == rd_s)));
    end

    assign instr_ready = !stall_in && !hazard_s && !flush;

    // Next-state values for the stage registers
    stage_state_e        state_n;
    logic [3:0]          opcode_n;
    logic [REG_ADDR-1:0] rd_n;
    logic [ARQ-1:0]      opa_n;
    logic [ARQ-1:0]      opb_n;
    logic [ARQ-1:0]      store_data_n;
    logic                wr_reg_en_n;
    logic                valid_n;
    logic [15:0]         issue_count_n;

    // Stage control: flush beats stall, stall beats the interlock, and only
    // a real accepted instruction advances the issue counter.
    always_comb begin
        state_n       = RUN;
        opcode_n      = opcode_r;
        rd_n          = rd_r;
        opa_n         = opa_r;
        opb_n         = opb_r;
        store_data_n  = store_data_r;
        wr_reg_en_n   = wr_reg_en_r;
        valid_n       = valid_r;
        issue_count_n = issue_count_r;
        if (flush) begin
            valid_n     = 1'b0;
            wr_reg_en_n = 1'b0;
            state_n     = RUN;
        end else if (stall_in) begin
            state_n = HOLD;
        end else if (hazard_s) begin
            valid_n     = 1'b0;
            wr_reg_en_n = 1'b0;
            state_n     = BUBBLE;
        end else if (instr_valid) begin
            opcode_n      = opcode_s;
            rd_n          = rd_s;
            opa_n         = rs1_data_s;
            opb_n         = dec_opb_s;
            store_data_n  = dec_store_s;
            wr_reg_en_n   = dec_wr_en_s;
            valid_n       = 1'b1;
            issue_count_n = issue_count_r + 16'd1;
            state_n       = RUN;
        end else begin
            valid_n     = 1'b0;
            wr_reg_en_n = 1'b0;
            state_n     = RUN;
        end
    end

    // Pipeline register toward the ALU stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= RUN;
            opcode_r      <= 4'd0;
            rd_r          <= {REG_ADDR{1'b0}};
            opa_r         <= {ARQ{1'b0}};
            opb_r         <= {ARQ{1'b0}};
            store_data_r  <= {ARQ{1'b0}};
            wr_reg_en_r   <= 1'b0;
            valid_r       <= 1'b0;
            issue_count_r <= 16'd0;
        end else begin
            state_r       <= state_n;
            opcode_r      <= opcode_n;
            rd_r          <= rd_n;
            opa_r         <= opa_n;
            opb_r         <= opb_n;
            store_data_r  <= store_data_n;
            wr_reg_en_r   <= wr_reg_en_n;
            valid_r       <= valid_n;
            issue_count_r <= issue_count_n;
        end
    end

endmodule

// File: tb/tb_decode_rf_stage.sv
// Directed bench for decode_rf_stage with hand-computed expectations.
module tb_decode_rf_stage;

    logic        clk;
    logic        rst;
    logic [15:0] instr_in;
    logic        instr_valid;
    logic        instr_ready;
    logic        stall_in;
    logic        flush;
    logic        wb_enable;
    logic [3:0]  wb_addr;
    logic [15:0] wb_result;
    logic [3:0]  opcode_out;
    logic [3:0]  rd_out;
    logic [15:0] opa_out;
    logic [15:0] opb_out;
    logic [15:0] store_data_out;
    logic        wr_reg_en_out;
    logic        valid_out;
    logic [15:0] issue_count;

    int n_vec;
    int n_miss;

    decode_rf_stage dut (
        .clk            (clk),
        .rst            (rst),
        .instr_in       (instr_in),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .stall_in       (stall_in),
        .flush          (flush),
        .wb_enable      (wb_enable),
        .wb_addr        (wb_addr),
        .wb_result      (wb_result),
        .opcode_out     (opcode_out),
        .rd_out         (rd_out),
        .opa_out        (opa_out),
        .opb_out        (opb_out),
        .store_data_out (store_data_out),
        .wr_reg_en_out  (wr_reg_en_out),
        .valid_out      (valid_out),
        .issue_count    (issue_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_vec       = 0;
        n_miss      = 0;
        rst         = 1'b1;
        instr_in    = 16'h0000;
        instr_valid = 1'b0;
        stall_in    = 1'b0;
        flush       = 1'b0;
        wb_enable   = 1'b0;
        wb_addr     = 4'd0;
        wb_result   = 16'h0000;

        // Reset
        repeat (2) step();
        check("rst_opcode", 32'(opcode_out), 32'h0);
        check("rst_rd", 32'(rd_out), 32'h0);
        check("rst_opa", 32'(opa_out), 32'h0);
        check("rst_opb", 32'(opb_out), 32'h0);
        check("rst_store", 32'(store_data_out), 32'h0);
        check("rst_wren", 32'(wr_reg_en_out), 32'h0);
        check("rst_valid", 32'(valid_out), 32'h0);
        check("rst_count", 32'(issue_count), 32'h0);
        check("rst_ready", 32'(instr_ready), 32'h1);
        rst = 1'b0;

        // R1..R15 read zero after reset: ADD r1, ri, ri
        for (int i = 1; i < 16; i++) begin
            instr_in    = {4'h0, 4'h1, 4'(i), 4'(i)};
            instr_valid = 1'b1;
            step();
            check($sformatf("r%0d_opa", i), 32'(opa_out), 32'h0);
            check($sformatf("r%0d_opb", i), 32'(opb_out), 32'h0);
        end
        check("cnt15", 32'(issue_count), 32'd15);

        // Writeback bypass: ADD r5,r3,r0 while R3 <- 0x1234
        wb_enable = 1'b1; wb_addr = 4'd3; wb_result = 16'h1234;
        instr_in  = 16'h0530;
        step();
        wb_enable = 1'b0;
        check("byp_opa", 32'(opa_out), 32'h1234);
        check("byp_opb", 32'(opb_out), 32'h0);
        check("byp_rd", 32'(rd_out), 32'h5);
        check("byp_valid", 32'(valid_out), 32'h1);
        check("byp_wren", 32'(wr_reg_en_out), 32'h1);
        // R3 holds the written value afterwards: ADD r7,r3,r3
        instr_in = 16'h0733;
        step();
        check("r3_opa", 32'(opa_out), 32'h1234);
        check("r3_opb", 32'(opb_out), 32'h1234);

        // R0 write ignored, then ADDI r2,r0,-1
        instr_valid = 1'b0;
        wb_enable = 1'b1; wb_addr = 4'd0; wb_result = 16'hFFFF;
        step();
        wb_enable = 1'b0;
        check("idle_valid", 32'(valid_out), 32'h0);
        instr_in = 16'h420F; instr_valid = 1'b1;
        step();
        check("addi_opa", 32'(opa_out), 32'h0);
        check("addi_opb", 32'(opb_out), 32'hFFFF);
        check("addi_op", 32'(opcode_out), 32'h4);
        check("addi_wren", 32'(wr_reg_en_out), 32'h1);

        // Reset again, then preload R1=0x0011, R2=0x00AB
        rst = 1'b1; instr_valid = 1'b0;
        step();
        rst = 1'b0;
        check("rst2_count", 32'(issue_count), 32'h0);
        wb_enable = 1'b1; wb_addr = 4'd1; wb_result = 16'h0011;
        step();
        wb_addr = 4'd2; wb_result = 16'h00AB;
        step();
        wb_enable = 1'b0;

        // Load-use: LOAD r4,(r1+0) then ADD r6,r4,r1
        instr_in = 16'h8410; instr_valid = 1'b1;
        step();
        check("ld_valid", 32'(valid_out), 32'h1);
        check("ld_op", 32'(opcode_out), 32'h8);
        check("ld_opa", 32'(opa_out), 32'h0011);
        check("ld_count", 32'(issue_count), 32'd1);
        instr_in = 16'h0641;
        #1;
        check("haz_ready", 32'(instr_ready), 32'h0);
        step();
        check("bub_valid", 32'(valid_out), 32'h0);
        check("bub_wren", 32'(wr_reg_en_out), 32'h0);
        check("bub_count", 32'(issue_count), 32'd1);
        check("bub_ready", 32'(instr_ready), 32'h1);
        step();
        check("use_valid", 32'(valid_out), 32'h1);
        check("use_rd", 32'(rd_out), 32'h6);
        check("use_opa", 32'(opa_out), 32'h0);
        check("use_opb", 32'(opb_out), 32'h0011);
        check("use_count", 32'(issue_count), 32'd2);

        // STORE r2,(r1+3)
        instr_in = 16'h9213;
        step();
        check("st_opa", 32'(opa_out), 32'h0011);
        check("st_opb", 32'(opb_out), 32'h0003);
        check("st_data", 32'(store_data_out), 32'h00AB);
        check("st_wren", 32'(wr_reg_en_out), 32'h0);
        check("st_count", 32'(issue_count), 32'd3);

        // Stall for 3 cycles with a different instruction offered
        instr_in = 16'h0512;
        step();
        check("pre_opb", 32'(opb_out), 32'h00AB);
        instr_in = 16'h0733; stall_in = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("stl_ready", 32'(instr_ready), 32'h0);
            step();
            check("stl_rd", 32'(rd_out), 32'h5);
            check("stl_opa", 32'(opa_out), 32'h0011);
            check("stl_valid", 32'(valid_out), 32'h1);
            check("stl_count", 32'(issue_count), 32'd4);
        end
        flush = 1'b1;
        step();
        check("fs_valid", 32'(valid_out), 32'h0);
        check("fs_wren", 32'(wr_reg_en_out), 32'h0);
        check("fs_count", 32'(issue_count), 32'd4);
        stall_in = 1'b0;
        #1;
        check("fl_ready", 32'(instr_ready), 32'h0);
        step();
        check("fl_valid", 32'(valid_out), 32'h0);
        flush = 1'b0;
        step();
        check("aft_valid", 32'(valid_out), 32'h1);
        check("aft_rd", 32'(rd_out), 32'h7);
        check("aft_count", 32'(issue_count), 32'd5);

        // Counter wrap with a stream of NOPs
        rst = 1'b1; instr_valid = 1'b0;
        step();
        rst = 1'b0;
        instr_in = 16'hF000; instr_valid = 1'b1;
        repeat (65535) step();
        check("wrap_ffff", 32'(issue_count), 32'hFFFF);
        check("nop_wren", 32'(wr_reg_en_out), 32'h0);
        step();
        check("wrap_zero", 32'(issue_count), 32'h0000);
        instr_valid = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/decode_rf_stage.md
Name: decode_rf_stage

Overview:
- Decode/register-read stage of the 16-bit pipeline; the consumer end of the writeback path.
- Owns the architectural register file and accepts the writeback stage's write (enable, address, result).
- Decodes the incoming instruction and reads operands, bypassing a same-cycle writeback.
- Issues a registered operand bundle to the ALU stage, with downstream stall, flush and a one-bubble load-use interlock.

Parameters:
- ARQ, 16, data/instruction width.
- REG_COUNT, 16, number of architectural registers.
- REG_ADDR, 4, register address width (log2 REG_COUNT).

Ports:
- clk  in  1  clock.
- rst  in  1  reset.
- instr_in  in  ARQ  fetched instruction.
- instr_valid  in  1  instr_in holds a real instruction this cycle.
- instr_ready  out  1  stage accepts instr_in this cycle (combinational).
- stall_in  in  1  downstream cannot accept; hold outputs.
- flush  in  1  squash the instruction in this stage.
- wb_enable  in  1  writeback write strobe.
- wb_addr  in  REG_ADDR  writeback destination.
- wb_result  in  ARQ  writeback data.
- opcode_out  out  4  issued opcode.
- rd_out  out  REG_ADDR  issued destination register.
- opa_out  out  ARQ  operand A.
- opb_out  out  ARQ  operand B.
- store_data_out  out  ARQ  store data.
- wr_reg_en_out  out  1  issued instruction writes a register.
- valid_out  out  1  issued bundle is real.
- issue_count  out  16  count of issued instructions.

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous, active-high. While rst is high at a clk edge, every output register clears to 0: opcode_out, rd_out, opa_out, opb_out, store_data_out, wr_reg_en_out, valid_out, issue_count. All registers are also 0 after reset.
- Instruction format:
  - opcode = [15:12], rd = [11:8], rs1 = [7:4], rs2 = [3:0].
  - imm4 = [3:0], sign-extended to ARQ.
- Register file:
  - REG_COUNT x ARQ, with 2 async read ports (rs1, rs2) plus 1 read on the rd field for STORE.
  - R0 always reads 0; writes to R0 are ignored.
  - Write occurs at the clk edge when wb_enable=1.
- Bypass: if wb_enable=1, wb_addr==read address, and address!=0, the read returns wb_result in the same cycle (write-through).
- Operand select:
  - ADDI, LOAD, STORE: opb = sext(imm4).
  - All other opcodes: opb = R[rs2].
  - opa = R[rs1] always.
  - store_data = R[rd] for STORE, else 0.
- wr_reg_en decode: 0 for STORE, BRANCH and NOP; 1 for all other opcodes.
- Hazard: hazard = valid_out & (opcode_out==LOAD) & (rd_out!=0) & instr_valid & (rd_out==rs1 | rd_out==rs2 | (STORE & rd_out==rd field)).
- instr_ready = !stall_in & !hazard & !flush.
- Stage FSM, states RUN, HOLD, BUBBLE, evaluated at each clk edge in this priority:
  1. rst: clear everything; state RUN.
  2. flush: valid_out=0, wr_reg_en_out=0; instruction not consumed; state RUN. Flush beats stall.
  3. stall_in: all outputs hold; state HOLD.
  4. hazard: insert a bubble (valid_out=0, wr_reg_en_out=0, other fields don't-care); state BUBBLE. The hazard clears the following cycle, so the penalty is exactly 1 cycle.
  5. instr_valid: capture the decoded bundle, valid_out=1, issue_count+1; state RUN.
  6. Otherwise: valid_out=0; state RUN.
- Latency: 1 cycle from acceptance to valid_out.
- issue_count: 16-bit, wraps 0xFFFF -> 0x0000; does not count bubbles, flushes or holds.
- Reset mid-stall or mid-bubble: returns to RUN with cleared outputs on the next edge.

Decomposition:
- Shared package pipe_pkg holds:
  - Opcode constants: ADD=0x0, SUB=0x1, AND=0x2, OR=0x3, ADDI=0x4, LOAD=0x8, STORE=0x9, BRANCH=0xA, NOP=0xF.
  - Stage state enum {RUN, HOLD, BUBBLE}.
  - Parameter defaults for ARQ and REG_ADDR.
- Sub-module reg_file holds the 3 async read ports, the single write port, the R0 rule and the write-through bypass.
- Decode, hazard logic and the pipeline register stay in decode_rf_stage.

Test Plan:
- Reset: hold rst high for 2 clk edges -> all outputs 0 and instr_ready=1; R1..R15 read 0.
- Writeback bypass: wb_enable=1, wb_addr=3, wb_result=0x1234, with instr ADD r5,r3,r0 (0x0530) issued the same cycle -> next cycle opa_out=0x1234, opb_out=0, rd_out=5, valid_out=1.
- R0 and immediate: wb write 0xFFFF to R0, then ADDI r2,r0,-1 (0x420F) -> opa_out=0 and opb_out=0xFFFF.
- Load-use: LOAD r4 (0x8410), then ADD r6,r4,r1 (0x0641) -> exactly one bubble (valid_out=0, instr_ready=0 for 1 cycle), then ADD issues; issue_count goes 1 -> 2 with no increment on the bubble.
- Stall/flush: stall_in=1 for 3 cycles -> outputs frozen; flush and stall_in asserted together -> valid_out=0 on the next edge.
- Counter wrap: preload to 0xFFFF by issuing 65535 instructions, then issue 1 more -> issue_count=0x0000.
